// File: rtl/perm_pkg.sv
// Shared types and index-domain maps for the permutation sequencer.
// The index maps give where a single bit moves under each word op.
package perm_pkg;

  typedef enum logic [1:0] {
    OP_ROT    = 2'd0,
    OP_GREV   = 2'd1,
    OP_SHFL   = 2'd2,
    OP_UNSHFL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [4:0] arg;
  } prog_entry_t;

  localparam prog_entry_t PROG_IDENTITY = '{op: OP_GREV, arg: 5'd0};

  // A shuffle stage k exchanges index bits k and k+1.
  function automatic logic [4:0] swap_bits(input logic [4:0] i, input int k);
    logic [4:0] r;
    r        = i;
    r[k]     = i[k+1];
    r[k+1]   = i[k];
    return r;
  endfunction

  function automatic logic [4:0] idx_map(input op_e op, input logic [4:0] arg,
                                         input logic [4:0] idx);
    logic [4:0] r;
    r = idx;
    case (op)
      OP_ROT:  r = idx - arg;
      OP_GREV: r = idx ^ arg;
      OP_SHFL: begin
        for (int k = 3; k >= 0; k--)
          if (arg[k]) r = swap_bits(r, k);
      end
      OP_UNSHFL: begin
        for (int k = 0; k <= 3; k++)
          if (arg[k]) r = swap_bits(r, k);
      end
      default: r = idx;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/perm_word_op.sv
// Combinational 32-bit word permutation: rotate-right, generalized reverse,
// and the zip (shfl) / unzip (unshfl) networks.
module perm_word_op
  import perm_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  arg,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [31:0] grev32(input logic [31:0] x, input logic [4:0] s);
    logic [31:0] r;
    r = x;
    if (s[0]) r = ((r & 32'h5555_5555) << 1)  | ((r & 32'hAAAA_AAAA) >> 1);
    if (s[1]) r = ((r & 32'h3333_3333) << 2)  | ((r & 32'hCCCC_CCCC) >> 2);
    if (s[2]) r = ((r & 32'h0F0F_0F0F) << 4)  | ((r & 32'hF0F0_F0F0) >> 4);
    if (s[3]) r = ((r & 32'h00FF_00FF) << 8)  | ((r & 32'hFF00_FF00) >> 8);
    if (s[4]) r = ((r & 32'h0000_FFFF) << 16) | ((r & 32'hFFFF_0000) >> 16);
    return r;
  endfunction

  function automatic logic [31:0] shfl_stage(input logic [31:0] x, input logic [31:0] ml,
                                             input logic [31:0] mr, input int n);
    return (x & ~(ml | mr)) | ((x << n) & ml) | ((x >> n) & mr);
  endfunction

  function automatic logic [31:0] shfl32(input logic [31:0] x, input logic [3:0] s);
    logic [31:0] r;
    r = x;
    if (s[3]) r = shfl_stage(r, 32'h00FF_0000, 32'h0000_FF00, 8);
    if (s[2]) r = shfl_stage(r, 32'h0F00_0F00, 32'h00F0_00F0, 4);
    if (s[1]) r = shfl_stage(r, 32'h3030_3030, 32'h0C0C_0C0C, 2);
    if (s[0]) r = shfl_stage(r, 32'h4444_4444, 32'h2222_2222, 1);
    return r;
  endfunction

  // Each stage is its own inverse, so unzip is the same stages reversed.
  function automatic logic [31:0] unshfl32(input logic [31:0] x, input logic [3:0] s);
    logic [31:0] r;
    r = x;
    if (s[0]) r = shfl_stage(r, 32'h4444_4444, 32'h2222_2222, 1);
    if (s[1]) r = shfl_stage(r, 32'h3030_3030, 32'h0C0C_0C0C, 2);
    if (s[2]) r = shfl_stage(r, 32'h0F00_0F00, 32'h00F0_00F0, 4);
    if (s[3]) r = shfl_stage(r, 32'h00FF_0000, 32'h0000_FF00, 8);
    return r;
  endfunction

  always_comb begin
    dout = din;
    case (op)
      OP_ROT:    dout = (din >> arg) | (din << (6'd32 - {1'b0, arg}));
      OP_GREV:   dout = grev32(din, arg);
      OP_SHFL:   dout = shfl32(din, arg[3:0]);
      OP_UNSHFL: dout = unshfl32(din, arg[3:0]);
      default:   dout = din;
    endcase
  end

endmodule

// File: rtl/perm_sequencer.sv
// Applies a programmed sequence of word permutations to a 32-bit job, one op
// per cycle. Define PERMSEQ_IDX_EN to also track one bit's position (in_idx/out_idx).
module perm_sequencer
  import perm_pkg::*;
#(
  parameter int N  = 8,
  parameter int LW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_addr,
  input  logic [1:0]           cfg_op,
  input  logic [4:0]           cfg_arg,
  output logic                 cfg_busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic [LW-1:0]        in_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data
`ifdef PERMSEQ_IDX_EN
  ,
  input  logic [4:0]           in_idx,
  output logic [4:0]           out_idx
`endif
);

  localparam int AW = $clog2(N);

  state_e       state_reg, state_next;
  logic [AW-1:0] step_reg;
  logic [LW-1:0] len_reg;
  logic [31:0]  data_reg;
  prog_entry_t  prog_reg [N];

  prog_entry_t  cur_entry;
  logic [31:0]  word_out;
  logic [LW-1:0] len_clamped;
  logic         last_step;
  logic         cfg_write;

  assign cur_entry   = prog_reg[step_reg];
  assign len_clamped = (in_len > LW'(N)) ? LW'(N) : in_len;
  assign last_step   = (LW'(step_reg) == len_reg - LW'(1));
  assign cfg_write   = cfg_we && (state_reg == ST_IDLE) && (int'(cfg_addr) < N);

  perm_word_op u_word_op (
    .op   (cur_entry.op),
    .arg  (cur_entry.arg),
    .din  (data_reg),
    .dout (word_out)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = (len_clamped == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign cfg_busy  = (state_reg != ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = data_reg;

  // A write landing with an accept is visible to that job: RUN reads next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) prog_reg[i] <= PROG_IDENTITY;
    end else if (cfg_write) begin
      prog_reg[cfg_addr] <= '{op: op_e'(cfg_op), arg: cfg_arg};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_reg <= '0;
      len_reg  <= '0;
      data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (in_valid) begin
          data_reg <= in_data;
          len_reg  <= len_clamped;
          step_reg <= '0;
        end
        ST_RUN: begin
          data_reg <= word_out;
          step_reg <= step_reg + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PERMSEQ_IDX_EN
  logic [4:0] idx_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (in_valid) idx_reg <= in_idx;
        ST_RUN:  idx_reg <= idx_map(cur_entry.op, cur_entry.arg, idx_reg);
        default: ;
      endcase
    end
  end

  assign out_idx = idx_reg;
`endif

endmodule

// File: tb/tb_perm_sequencer.sv
// Directed bench for perm_sequencer: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every out_valid&out_ready.
module tb_perm_sequencer;
  import perm_pkg::*;

  localparam int N  = 8;
  localparam int LW = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [1:0]    cfg_op = '0;
  logic [4:0]    cfg_arg = '0;
  logic          cfg_busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
`ifdef PERMSEQ_IDX_EN
  logic [4:0]    in_idx = '0;
  logic [4:0]    out_idx;
`endif

  typedef struct {
    logic [31:0] d;
    logic [4:0]  i;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  perm_sequencer #(.N(N), .LW(LW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_op    (cfg_op),
    .cfg_arg   (cfg_arg),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PERMSEQ_IDX_EN
    ,
    .in_idx    (in_idx),
    .out_idx   (out_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no result (t=%0t)", out_data, $time);
      end else begin
        e = sb_q.pop_front();
        n_txn++;
`ifdef PERMSEQ_IDX_EN
        $display("txn %0d: out_data=%h exp=%h out_idx=%0d exp_idx=%0d",
                 n_txn, out_data, e.d, out_idx, e.i);
        check("out_idx", {27'd0, out_idx}, {27'd0, e.i});
`else
        $display("txn %0d: out_data=%h exp=%h", n_txn, out_data, e.d);
`endif
        check("out_data", out_data, e.d);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input logic [AW-1:0] a, input logic [1:0] op, input logic [4:0] arg);
    cfg_we = 1'b1; cfg_addr = a; cfg_op = op; cfg_arg = arg;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] d, input logic [LW-1:0] len, input logic [4:0] ii,
                         input logic [31:0] ed, input logic [4:0] ei, input int lat_exp,
                         input bit wcfg = 1'b0, input logic [AW-1:0] wa = '0,
                         input logic [1:0] wo = '0, input logic [4:0] warg = '0);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_len = len;
`ifdef PERMSEQ_IDX_EN
    in_idx = ii;
`else
    if (ii != ei) begin end
`endif
    if (wcfg) begin cfg_we = 1'b1; cfg_addr = wa; cfg_op = wo; cfg_arg = warg; end
    sb_q.push_back('{d: ed, i: ei});
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      check("in_ready_run", {31'd0, in_ready}, 32'd0);
      check("cfg_busy_run", {31'd0, cfg_busy}, 32'd1);
      @(posedge clk); #1; n++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    check("latency", n, lat_exp);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic finish_job();
    int n;
    n = 0;
    while (out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("out_valid_release", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_cfg_busy",  {31'd0, cfg_busy},  32'd0);
    check("rst_out_data",  out_data, 32'd0);
`ifdef PERMSEQ_IDX_EN
    check("rst_out_idx", {27'd0, out_idx}, 32'd0);
`endif
    resetn = 1'b1;
    @(posedge clk); #1;

    // len 0 passes the word straight through
    run_job(32'hDEAD_BEEF, 4'd0, 5'd5, 32'hDEAD_BEEF, 5'd5, 0);
    finish_job();

    // write on the accept cycle is seen by that job
    run_job(32'h0000_0001, 4'd1, 5'd0, 32'h8000_0000, 5'd31, 1, 1'b1, 3'd0, OP_GREV, 5'd31);
    finish_job();

    cfg_write(3'd0, OP_ROT, 5'd1);
    run_job(32'h0000_0001, 4'd1, 5'd0, 32'h8000_0000, 5'd31, 1);
    finish_job();

    cfg_write(3'd0, OP_GREV, 5'd24);
    run_job(32'h1122_3344, 4'd1, 5'd0, 32'h4433_2211, 5'd24, 1);
    finish_job();

    cfg_write(3'd0, OP_SHFL, 5'd15);
    run_job(32'h0000_FFFF, 4'd1, 5'd16, 32'h5555_5555, 5'd1, 1);
    finish_job();

    cfg_write(3'd0, OP_UNSHFL, 5'd15);
    run_job(32'h5555_5555, 4'd1, 5'd1, 32'h0000_FFFF, 5'd16, 1);
    finish_job();

    cfg_write(3'd0, OP_SHFL, 5'd15);
    cfg_write(3'd1, OP_UNSHFL, 5'd15);
    cfg_write(3'd2, OP_GREV, 5'd31);
    run_job(32'h0000_0001, 4'd3, 5'd0, 32'h8000_0000, 5'd31, 3);
    finish_job();

    // backpressure in DONE; a config write there must be dropped
    out_ready = 1'b0;
    run_job(32'h0000_0003, 4'd3, 5'd1, 32'hC000_0000, 5'd30, 3);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_op = OP_ROT; cfg_arg = 5'd5; end
      else cfg_we = 1'b0;
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data",  out_data, 32'hC000_0000);
      check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    finish_job();
    run_job(32'h0000_0001, 4'd3, 5'd0, 32'h8000_0000, 5'd31, 3);
    finish_job();

    // in_len above N clamps to N: eight ROT 1 ops
    for (int a = 0; a < N; a++) cfg_write(AW'(a), OP_ROT, 5'd1);
    run_job(32'h0000_0001, 4'd15, 5'd0, 32'h0100_0000, 5'd24, 8);
    finish_job();

    // reset at step 2 of a len 5 job
    in_valid = 1'b1; in_data = 32'hA5A5_0001; in_len = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run_busy", {31'd0, cfg_busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_cfg_busy",  {31'd0, cfg_busy},  32'd0);
    check("abort_out_data",  out_data, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    // program store back to identity: eight ops leave the word unchanged
    run_job(32'h1234_5678, 4'd8, 5'd7, 32'h1234_5678, 5'd7, 8);
    finish_job();

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
